// File: rtl/add_share_arb.sv
// Two-requester add/subtract unit sharing one SLICE-bit adder; each operand pair is
// summed least-significant slice first, one slice per clock, with round-robin arbitration.
module add_share_arb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_cout,
    output logic             resp_ovf
);

    localparam int unsigned NumSlices = WIDTH / SLICE;
    localparam int unsigned IdxW      = $clog2(NumSlices);

    typedef enum logic [1:0] {StIdle, StRun, StDone} stateT;

    stateT            stateQ, stateD;
    logic [IdxW-1:0]  idxQ, idxD;
    logic             carryQ, carryD;
    logic [WIDTH-1:0] aQ, aD, bQ, bD, resQ, resD;
    logic             idQ, idD;
    logic             lastQ, lastD;

    logic             grant0, grant1;
    logic [31:0]      sliceOff;
    logic [SLICE:0]   sliceSum;

    // Both valid: the requester not granted last time wins.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || lastQ);
        grant1     = req1_valid && (!req0_valid || !lastQ);
        req0_ready = resetn && (stateQ == StIdle) && grant0;
        req1_ready = resetn && (stateQ == StIdle) && grant1;
    end

    always_comb begin
        sliceOff = 32'(idxQ) * SLICE;
        sliceSum = {1'b0, aQ[sliceOff +: SLICE]} + {1'b0, bQ[sliceOff +: SLICE]}
                 + {{SLICE{1'b0}}, carryQ};
    end

    always_comb begin
        stateD = stateQ;
        idxD   = idxQ;
        carryD = carryQ;
        aD     = aQ;
        bD     = bQ;
        resD   = resQ;
        idD    = idQ;
        lastD  = lastQ;
        unique case (stateQ)
            StIdle: begin
                if (req0_ready || req1_ready) begin
                    // Subtraction as a + ~b + 1: the +1 rides in on the initial carry.
                    aD     = grant1 ? req1_a : req0_a;
                    bD     = grant1 ? (req1_b ^ {WIDTH{req1_sub}}) : (req0_b ^ {WIDTH{req0_sub}});
                    carryD = grant1 ? req1_sub : req0_sub;
                    idD    = grant1;
                    lastD  = grant1;
                    idxD   = '0;
                    stateD = StRun;
                end
            end
            StRun: begin
                resD[sliceOff +: SLICE] = sliceSum[SLICE-1:0];
                carryD                  = sliceSum[SLICE];
                if (idxQ == IdxW'(NumSlices - 1)) begin
                    idxD   = '0;
                    stateD = StDone;
                end else begin
                    idxD = idxQ + 1'b1;
                end
            end
            StDone: begin
                if (resp_ready) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stateQ <= StIdle;
            idxQ   <= '0;
            carryQ <= 1'b0;
            aQ     <= '0;
            bQ     <= '0;
            resQ   <= '0;
            idQ    <= 1'b0;
            lastQ  <= 1'b1;
        end else begin
            stateQ <= stateD;
            idxQ   <= idxD;
            carryQ <= carryD;
            aQ     <= aD;
            bQ     <= bD;
            resQ   <= resD;
            idQ    <= idD;
            lastQ  <= lastD;
        end
    end

    always_comb begin
        resp_valid = (stateQ == StDone);
        resp_sum   = resQ;
        resp_id    = idQ;
        resp_cout  = carryQ;
        resp_ovf   = resp_valid && (aQ[WIDTH-1] == bQ[WIDTH-1]) && (resQ[WIDTH-1] != aQ[WIDTH-1]);
    end

endmodule

// File: tb/tb_add_share_arb.sv
// Self-checking bench for add_share_arb: directed, contention, random, backpressure and
// mid-operation reset scenarios scored against an arithmetic reference model.
module tb_add_share_arb;

    localparam int unsigned W = 32;
    localparam int unsigned S = 8;
    localparam int unsigned N = W / S;

    logic         clk = 1'b0;
    logic         resetn;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_sub, req1_sub;
    logic         resp_valid, resp_ready, resp_id, resp_cout, resp_ovf;
    logic [W-1:0] resp_sum;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit lastModel = 1'b1;

    add_share_arb #(.WIDTH(W), .SLICE(S)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_ovf   (resp_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } resT;

    // Reference: plain integer arithmetic on the operands.
    function automatic resT refModel(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub);
        resT    r;
        longint sr;
        logic [W:0] wide;
        sr     = sub ? (longint'(signed'(a)) - longint'(signed'(b)))
                     : (longint'(signed'(a)) + longint'(signed'(b)));
        r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        wide   = {1'b0, a} + {1'b0, b};
        r.cout = sub ? (a >= b) : wide[W];
        r.sum  = sub ? (a - b) : (a + b);
        return r;
    endfunction

    function automatic bit refGrant(input bit v0, input bit v1);
        if (v0 && v1) return !lastModel;
        return v1;
    endfunction

    // Drives one request to completion of its response (FSM left in DONE); no checking here.
    task automatic run_op(input bit v0, input bit v1,
                          input logic [W-1:0] a0, input logic [W-1:0] b0, input bit s0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1, input bit s1,
                          input bit hold,
                          output bit grantId, output bit respId, output int edges,
                          output resT got, output int hsCycle,
                          output bit timedOut, output bit bothSeen, output bit busyReady);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
        timedOut = 1'b1; bothSeen = 1'b0; busyReady = 1'b0;
        grantId = 1'b0; respId = 1'b0; edges = 0; got = '0; hsCycle = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_ready && req1_ready) bothSeen = 1'b1;
            if (req0_ready || req1_ready) begin
                grantId  = req1_ready;
                timedOut = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        if (timedOut) return;
        @(posedge clk); #1;
        hsCycle = cyc;
        edges   = 1;
        if (!hold) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            req0_a = $urandom; req0_b = $urandom; req0_sub = 1'($urandom);
            req1_a = $urandom; req1_b = $urandom; req1_sub = 1'($urandom);
        end
        timedOut = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req0_ready || req1_ready) busyReady = 1'b1;
            @(posedge clk); #1;
            edges++;
            if (resp_valid) begin
                timedOut = 1'b0;
                break;
            end
        end
        got.sum  = resp_sum;
        got.cout = resp_cout;
        got.ovf  = resp_ovf;
        respId   = resp_id;
    endtask

    task automatic test_reset();
        resetn = 1'b0; resp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
        end
        checks++;
        if ({resp_valid, resp_id, resp_cout, resp_ovf} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {resp_valid, resp_id, resp_cout, resp_ovf});
        end
        checks++;
        if (resp_sum !== '0) begin
            errors++; $display("FAIL reset_sum: got %h want 0", resp_sum);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1 resetn = 1'b1;
        #1 req0_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL first_ready_after_reset: got %b want 1", req0_ready);
        end
        req0_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        bit gid, rid, to, both, busy;
        int edges, hs, prevHs;
        resT got, exp;
        logic [W-1:0] a0, b0, a1, b1;
        bit s0, s1, expId;
        bit order[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        resp_ready = 1'b1;
        prevHs = 0;
        for (int k = 0; k < 4; k++) begin
            a0 = $urandom; b0 = $urandom; s0 = 1'($urandom);
            a1 = $urandom; b1 = $urandom; s1 = 1'($urandom);
            expId = refGrant(1'b1, 1'b1);
            run_op(1'b1, 1'b1, a0, b0, s0, a1, b1, s1, 1'b1, gid, rid, edges, got, hs, to, both, busy);
            checks++;
            if (to) begin
                errors++; $display("FAIL contention_timeout op %0d: got timeout want response", k);
                continue;
            end
            lastModel = expId;
            exp = expId ? refModel(a1, b1, s1) : refModel(a0, b0, s0);
            checks++;
            if (gid !== order[k] || rid !== order[k]) begin
                errors++;
                $display("FAIL contention_order op %0d: got grant %0d id %0d want %0d", k, gid, rid, order[k]);
            end
            checks++;
            if (both || busy) begin
                errors++; $display("FAIL contention_ready op %0d: got both=%0d busy=%0d want 0 0", k, both, busy);
            end
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL contention_result op %0d: got %h want %h", k, got, exp);
            end
            if (k > 0) begin
                checks++;
                if (hs - prevHs != N + 2) begin
                    errors++; $display("FAIL contention_throughput op %0d: got %0d want %0d", k, hs - prevHs, N + 2);
                end
            end
            prevHs = hs;
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    typedef struct {
        bit           v0, v1;
        logic [W-1:0] a, b;
        bit           sub;
        logic [W-1:0] sum;
        bit           cout, ovf, id;
    } vecT;

    task automatic test_directed();
        bit gid, rid, to, both, busy;
        int edges, hs;
        resT got;
        vecT v[4];
        v[0] = '{1'b1, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        v[1] = '{1'b0, 1'b1, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1};
        v[2] = '{1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        v[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_op(v[k].v0, v[k].v1, v[k].a, v[k].b, v[k].sub, v[k].a, v[k].b, v[k].sub, 1'b0,
                   gid, rid, edges, got, hs, to, both, busy);
            checks++;
            if (to) begin
                errors++; $display("FAIL directed_timeout vec %0d: got timeout want response", k);
                continue;
            end
            lastModel = v[k].id;
            checks++;
            if (got.sum !== v[k].sum) begin
                errors++; $display("FAIL directed_sum vec %0d: got %h want %h", k, got.sum, v[k].sum);
            end
            checks++;
            if ({got.cout, got.ovf, rid} !== {v[k].cout, v[k].ovf, v[k].id}) begin
                errors++;
                $display("FAIL directed_flags vec %0d: got cout/ovf/id %b want %b", k,
                         {got.cout, got.ovf, rid}, {v[k].cout, v[k].ovf, v[k].id});
            end
            // Handshake edge counts as edge 1.
            checks++;
            if (edges != N + 1) begin
                errors++; $display("FAIL directed_latency vec %0d: got %0d edges want %0d", k, edges, N + 1);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        bit gid, rid, to, both, busy, v0, v1, s0, s1, expId;
        int edges, hs;
        int unsigned r;
        resT got, exp;
        logic [W-1:0] a0, b0, a1, b1;
        resp_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            r  = $urandom_range(1, 3);
            v0 = r[0]; v1 = r[1];
            a0 = $urandom; b0 = $urandom; s0 = 1'($urandom);
            a1 = $urandom; b1 = $urandom; s1 = 1'($urandom);
            if (k % 4 == 0) begin
                a0 = 32'h8000_0000; b0 = 32'h8000_0000;
            end
            expId = refGrant(v0, v1);
            exp   = expId ? refModel(a1, b1, s1) : refModel(a0, b0, s0);
            run_op(v0, v1, a0, b0, s0, a1, b1, s1, 1'b0, gid, rid, edges, got, hs, to, both, busy);
            checks++;
            if (to) begin
                errors++; $display("FAIL random_timeout op %0d: got timeout want response", k);
                continue;
            end
            lastModel = expId;
            checks++;
            if (rid !== expId || gid !== expId || both) begin
                errors++;
                $display("FAIL random_grant op %0d: got grant %0d id %0d both %0d want %0d", k, gid, rid, both, expId);
            end
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random_result op %0d: got %h want %h", k, got, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        bit gid, rid, to, both, busy;
        int edges, hs;
        resT got, exp;
        logic [W-1:0] a, b;
        bit s;
        a = $urandom; b = $urandom; s = 1'b1;
        exp = refModel(a, b, s);
        resp_ready = 1'b0;
        run_op(1'b1, 1'b0, a, b, s, a, b, s, 1'b0, gid, rid, edges, got, hs, to, both, busy);
        checks++;
        if (to) begin
            errors++; $display("FAIL bp_timeout: got timeout want response");
            resp_ready = 1'b1;
            return;
        end
        lastModel = 1'b0;
        checks++;
        if (got !== exp || rid !== 1'b0) begin
            errors++; $display("FAIL bp_result: got %h id %0d want %h id 0", got, rid, exp);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (!resp_valid || {resp_sum, resp_cout, resp_ovf} !== got || resp_id !== rid
                || req0_ready || req1_ready) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got v=%0d %h id %0d rdy %0d%0d want v=1 %h id %0d rdy 00",
                         i, resp_valid, {resp_sum, resp_cout, resp_ovf}, resp_id, req0_ready, req1_ready,
                         got, rid);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got v=%0d rdy %0d%0d want v=0 rdy 01", resp_valid, req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        bit gid, rid, to, both, busy;
        int edges, hs;
        resT got, exp;
        logic [W-1:0] a0, b0, a1, b1;
        resp_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 32'h1234_5678; req1_b = 32'h1111_1111; req1_sub = 1'b0;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_ready: got %b want 1", req1_ready);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        resetn = 1'b0;
        #1;
        lastModel = 1'b1;
        checks++;
        if ({resp_valid, resp_id, resp_cout, resp_ovf, req0_ready, req1_ready} !== 6'b0 || resp_sum !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got v/id/c/o/r0/r1 %b sum %h want 000000 sum 0",
                     {resp_valid, resp_id, resp_cout, resp_ovf, req0_ready, req1_ready}, resp_sum);
        end
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_no_resp: got %b want 0", resp_valid);
        end
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        exp = refModel(a0, b0, 1'b0);
        run_op(1'b1, 1'b1, a0, b0, 1'b0, a1, b1, 1'b1, 1'b0, gid, rid, edges, got, hs, to, both, busy);
        checks++;
        if (to) begin
            errors++; $display("FAIL midrst_timeout: got timeout want response");
            return;
        end
        lastModel = 1'b0;
        checks++;
        if (rid !== 1'b0 || got !== exp || edges != N + 1) begin
            errors++;
            $display("FAIL midrst_fresh: got id %0d %h edges %0d want id 0 %h edges %0d", rid, got, edges, exp, N + 1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
